// File: rtl/mips_pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline sequencing controller.
package mips_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    MDU_WAIT = 3'd2,
    DRAIN    = 3'd3,
    HALT     = 3'd4
  } state_e;

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// Bundle between the pipeline datapath (master) and its sequencing controller (slave).
interface mips_pipe_ctrl_if;
  import mips_pipe_pkg::*;

  logic                  start;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_is_mdu;
  logic                  id_is_halt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_branch_taken;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  mdu_start;
  logic                  halted;
  logic [15:0]           stall_cycles;
  logic [15:0]           flush_count;

  modport master (
    output start, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_is_halt,
           ex_mem_read, ex_rd, ex_branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, mdu_start, halted,
           stall_cycles, flush_count
  );

  modport slave (
    input  start, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_is_halt,
           ex_mem_read, ex_rd, ex_branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, mdu_start, halted,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/mips_pipe_ctrl_load_use.sv
// Load-use hazard comparator: requests a stall when ID reads the register a load in EX writes.
module mips_load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  output logic                  stall_req_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rd_i);

  // $zero is never really written, so a load targeting it creates no hazard.
  assign stall_req_o = ex_mem_read_i && (ex_rd_i != ZERO_REG) && (rs_hit || rt_hit);

endmodule

// File: rtl/mips_pipe_ctrl.sv
// 5-stage MIPS pipeline sequencer: hazards, branch squash, MDU interlock, HALT drain.
// Optional perf counters are built when PIPE_PERF_EN is defined.
module mips_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MDU_LAT   = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mips_pipe_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  logic pc_en, if_id_en, if_id_flush, id_ex_bubble, mdu_start;

  mips_load_use_detect u_load_use (
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_uses_rs_i  (bus.id_uses_rs),
    .id_uses_rt_i  (bus.id_uses_rt),
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rd_i       (bus.ex_rd),
    .stall_req_o   (load_use)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mdu_start    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end

      RUN: begin
        if (bus.ex_branch_taken) begin
          // Everything in ID is on the wrong path, so its hazards are moot.
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          id_ex_bubble = 1'b1;
        end else if (bus.id_is_mdu) begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          mdu_start = 1'b1;
          state_d   = MDU_WAIT;
          cnt_d     = 4'(MDU_LAT - 1);
        end else if (bus.id_is_halt) begin
          id_ex_bubble = 1'b1;
          state_d      = DRAIN;
          cnt_d        = 4'(DRAIN_CYC - 1);
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end

      MDU_WAIT: begin
        id_ex_bubble = 1'b1;
        cnt_d        = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RUN;
      end

      DRAIN: begin
        id_ex_bubble = 1'b1;
        if (cnt_q == 4'd0) state_d = HALT;
        else               cnt_d   = cnt_q - 4'd1;
      end

      HALT: ;

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.mdu_start    = mdu_start;
  assign bus.halted       = (state_q == HALT);

`ifdef PIPE_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic        stall_inc, flush_inc;

  assign stall_inc = ((state_q == RUN) || (state_q == MDU_WAIT)) && !pc_en;
  assign flush_inc = (state_q == RUN) && bus.ex_branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_inc && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = 16'd0;
  assign bus.flush_count  = 16'd0;
`endif

endmodule

// File: doc/mips_pipe_ctrl.md
Name: mips_pipe_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Drives PC and IF/ID write enables, IF/ID flush, and ID/EX bubble insertion.
- Detects load-use hazards and squashes on taken branches.
- Interlocks the pipeline while a multi-cycle multiply/divide unit (MDU) runs.
- Drains the pipeline on a HALT instruction and holds it stopped.

Parameters:
REG_ADDR_W, 5, register specifier width.
MDU_LAT, 4, MDU occupancy in cycles including the issue cycle; legal range 2..15.
DRAIN_CYC, 3, cycles spent retiring EX/MEM/WB after HALT is seen in ID.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leaves IDLE and begins fetching
id_rs  in  REG_ADDR_W  rs field of the instruction in ID
id_rt  in  REG_ADDR_W  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_mdu  in  1  ID instruction is mult/div
id_is_halt  in  1  ID instruction is HALT
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_ADDR_W  destination register of the EX instruction
ex_branch_taken  in  1  branch resolved taken in EX
pc_en  out  1  PC register write enable
if_id_en  out  1  IF/ID register write enable
if_id_flush  out  1  IF/ID register loads a NOP
id_ex_bubble  out  1  ID/EX register loads control zeros
mdu_start  out  1  single-cycle MDU launch pulse
halted  out  1  pipeline stopped after HALT
stall_cycles  out  16  perf counter (see Optional Feature)
flush_count  out  16  perf counter (see Optional Feature)

Behaviour:
- Clocking and reset: single clock clk; rst_n is asynchronous and active-low.
- Registered state is {IDLE, RUN, MDU_WAIT, DRAIN, HALT} plus a 4-bit down-counter cnt.
- On reset: state=IDLE, cnt=0, and both perf counters are cleared.
- Stage-control outputs (pc_en, if_id_en, if_id_flush, id_ex_bubble, mdu_start) are combinational from state and the current inputs. halted is a decode of state.
- Reset output values (IDLE): pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=0, mdu_start=0, halted=0.
- IDLE: start=1 moves to RUN on the next edge. Outputs stay at their idle values.
- RUN, default: pc_en=1, if_id_en=1, no flush, no bubble.
- RUN priority, highest first:
  1. Branch taken (ex_branch_taken=1): pc_en=1, if_id_flush=1, id_ex_bubble=1. Any hazard, MDU or HALT in ID is ignored because it is squashed. flush_count increments.
  2. Load-use (ex_mem_read=1, ex_rd!=0, and id_uses_rs with id_rs==ex_rd, or id_uses_rt with id_rt==ex_rd): pc_en=0, if_id_en=0, id_ex_bubble=1. The stall lasts exactly 1 cycle. stall_cycles increments.
  3. MDU (id_is_mdu=1): mdu_start=1 and the instruction advances normally. Next state is MDU_WAIT with cnt=MDU_LAT-1.
  4. HALT (id_is_halt=1): HALT advances as a bubble (id_ex_bubble=1), pc_en=0, if_id_en=0. Next state is DRAIN with cnt=DRAIN_CYC-1.
- Forwarded ALU-to-ALU dependencies never stall.
- MDU_WAIT: pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cycles increments each cycle. cnt decrements each cycle; when cnt==1 the next state is RUN. Total pipeline freeze is MDU_LAT-1 cycles after the issue cycle. ex_branch_taken cannot be asserted here because only bubbles follow; it is ignored.
- DRAIN: same freeze outputs as MDU_WAIT. When cnt==0 the next state is HALT; otherwise cnt decrements.
- HALT: halted=1, all other stage controls 0, start ignored. Only reset exits HALT.
- Reset asserted mid-MDU_WAIT or mid-DRAIN returns to IDLE immediately and clears cnt.

Optional Feature:
Macro PIPE_PERF_EN.
- Defined: stall_cycles counts every cycle with pc_en=0 in RUN/MDU_WAIT. flush_count counts taken-branch flushes. Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package mips_pipe_pkg holds:
  - state enum (IDLE, RUN, MDU_WAIT, DRAIN, HALT)
  - REG_ADDR_W
  - zero-register constant 5'd0
- Natural sub-module: mips_load_use_detect, a pure combinational comparator producing the load-use stall request from the id_* and ex_* fields.

Test Plan:
- Reset then start=1 → pc_en=1, if_id_en=1 from the next cycle. ADD R2,R7,R9 in EX with SUB R3,R2,R10 in ID (ex_mem_read=0) → no stall, no bubble.
- LW R2 in EX (ex_mem_read=1, ex_rd=2) with SUB R3,R2,R10 in ID → exactly one cycle of pc_en=0, id_ex_bubble=1, then normal flow; stall_cycles=1. Same case with ex_rd=0 → no stall.
- ex_branch_taken=1 in the same cycle as a load-use match → if_id_flush=1, id_ex_bubble=1, pc_en=1, no stall; flush_count=1.
- id_is_mdu with MDU_LAT=4 → mdu_start pulse of 1 cycle, then 3 cycles of pc_en=0, then RUN. Deassert rst_n during the 2nd wait cycle → all outputs 0 at once, state IDLE.
- id_is_halt → 1 freeze cycle plus DRAIN_CYC=3 drain cycles, then halted=1. start=1 in HALT → no change.
